// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: opcode constants, default reset PC, fetch entry, FSM states.
// No logic of its own; no latency.
// No flow control; consumers decide how entries move.
package riscv_pkg;

  localparam logic [6:0]  R_TYPE_OP        = 7'b0110011;
  localparam logic [6:0]  I_TYPE_OP        = 7'b0010011;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered fetch: address of the word and the word itself.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  // Decoder presentation handshake states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_BUSY  = 2'd2
  } pres_state_t;

  // Only register-register and register-immediate ALU ops are accepted.
  function automatic logic is_illegal(input logic [31:0] insn);
    return !((insn[6:0] == R_TYPE_OP) || (insn[6:0] == I_TYPE_OP));
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO for fetched words, with flush that can optionally preserve the head.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: none; the producer guarantees it never pushes when full (extra pushes are dropped).
module ifetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [63:0]              i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic                     i_keep_head,
  output logic [63:0]              o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_do_push;
  logic          w_do_pop;

  // Next pointers/count; a flush leaves either nothing or just the surviving head.
  always_comb begin
    w_do_pop     = i_pop && (r_count != '0);
    w_do_push    = i_push && !i_flush && (r_count != CW'(DEPTH));
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_do_pop);
    w_wr_ptr_nxt = r_wr_ptr + AW'(w_do_push);
    w_count_nxt  = r_count + CW'(w_do_push) - CW'(w_do_pop);
    if (i_flush) begin
      w_count_nxt  = (i_keep_head && !w_do_pop && (r_count != '0)) ? CW'(1) : '0;
      w_wr_ptr_nxt = w_rd_ptr_nxt + AW'(w_count_nxt);
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: in-order imem reads into a prefetch FIFO, presented to the decoder via RDY_BSY/dec_done.
// Latency: response in cycle N gives an RDY_BSY pulse in cycle N+2 when idle and empty; optional IFETCH_ILLEGAL_CHECK_EN adds the illegal output.
// Backpressure: requests are throttled so outstanding + buffered words never exceed FIFO_DEPTH; a redirect drops stale words.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        RDY_BSY,
  input  logic        dec_done
`ifdef IFETCH_ILLEGAL_CHECK_EN
  ,
  output logic        illegal
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_instruction;
  logic [31:0]   r_pc;
  logic          r_rdy_bsy;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  pres_state_t   r_state;
  pres_state_t   w_state_nxt;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] w_fifo_count;
  logic [CW:0]   w_inflight;
  logic [31:0]   w_redirect_pc;
  logic [63:0]   w_head_raw;
  fetch_entry_t  w_head;
  logic          w_accept;
  logic          w_rsp_keep;
  logic          w_load;
  logic          w_pop;

  assign w_redirect_pc     = redirect_pc & 32'hFFFF_FFFC;
  assign w_inflight        = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign imem_req_valid    = rst && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign w_accept          = imem_req_valid && imem_req_ready;
  assign w_rsp_keep        = imem_rsp_valid && (r_discard == '0) && !redirect_valid;
  assign w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);
  assign w_head            = fetch_entry_t'(w_head_raw);

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_rsp_keep),
    .i_push_dat  ({r_rsp_pc, imem_rsp_data}),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .i_keep_head (r_state != S_IDLE),
    .o_head      (w_head_raw),
    .o_count     (w_fifo_count)
  );

  // Fetch PC, response address tracking, and stale-response accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old stream.
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_discard  <= w_outstanding_nxt;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (imem_rsp_valid) begin
          if (r_discard != '0) begin
            r_discard <= r_discard - CW'(1);
          end else begin
            r_rsp_pc <= r_rsp_pc + 32'd4;
          end
        end
      end
    end
  end

  // Presentation state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Presentation next state; an IDLE load is skipped on redirect since the head is being flushed.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_fifo_count != '0) && !redirect_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_PULSE;
        end
      end
      S_PULSE: w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (dec_done) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered decoder-facing outputs, loaded from the FIFO head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instruction <= '0;
      r_pc          <= RESET_PC;
      r_rdy_bsy     <= 1'b0;
    end else begin
      r_rdy_bsy <= w_load;
      if (w_load) begin
        r_instruction <= w_head.insn;
        r_pc          <= w_head.pc;
      end
    end
  end

  assign imem_addr   = r_fetch_pc;
  assign instruction = r_instruction;
  assign pc          = r_pc;
  assign RDY_BSY     = r_rdy_bsy;

`ifdef IFETCH_ILLEGAL_CHECK_EN
  logic r_illegal;

  // Legality flag loaded with the instruction so both change together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_illegal <= 1'b0;
    end else if (w_load) begin
      r_illegal <= is_illegal(w_head.insn);
    end
  end

  assign illegal = r_illegal;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized memory/decoder/redirect stimulus against a stream-level model.
// Expected decoder words are queued at each accepted request and popped by the pulse monitor.
// Memory responds in order with random latency; the decoder stalls randomly.
module tb_instr_fetch;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        RDY_BSY;
  logic        dec_done = 1'b0;
`ifdef IFETCH_ILLEGAL_CHECK_EN
  logic        illegal;
`endif

  instr_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instruction    (instruction),
    .pc             (pc),
    .RDY_BSY        (RDY_BSY),
    .dec_done       (dec_done)
`ifdef IFETCH_ILLEGAL_CHECK_EN
    ,
    .illegal        (illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] insn; } exp_t;

  mreq_t       mq[$];
  exp_t        exp_q[$];
  exp_t        cur;
  int          n_vec = 0, n_err = 0;
  int          cyc = 0, phase = 0, last_due = -1, first_rsp_cyc = -1;
  int          n_acc = 0, n_pulses = 0, dec_cnt = 0;
  int          ready_pct = 100, lat_min = 1, lat_max = 1, dec_max = 2, spur_pct = 0, redir_pct = 0;
  int          b1_cyc = 0;
  bit          dec_busy = 1'b0, b1_done = 1'b0, b2_done = 1'b0, c_done = 1'b0;
  bit          acc_chk = 1'b0, pulse_chk = 1'b0, wrap_chk = 1'b0;
  logic [31:0] exp_req_addr = RST_PC, acc_exp = '0, pulse_exp = '0;

  // Instruction memory contents; a few fixed words at low addresses, hashed elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h8) return 32'h0000_0073;
    if (a == 32'hC) return 32'h0020_81B3;
    h = (a * 32'h9E37_79B1) ^ (a >> 5);
    case (h[9:8])
      2'd0:    op = 7'b0110011;
      2'd1:    op = 7'b0010011;
      2'd2:    op = 7'b1110011;
      default: op = 7'b0000011;
    endcase
    return {h[31:7], op};
  endfunction

  function automatic logic exp_illegal(input logic [31:0] w);
    return !((w[6:0] == 7'b0110011) || (w[6:0] == 7'b0010011));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: monitor outputs, drive inputs, then update the reference model.
  task automatic cycle_step();
    mreq_t       m;
    exp_t        e;
    int          due;
    int          n_out;
    logic [31:0] tgt;
    bit          pulse, acc, redir;
    #1;
    pulse = 1'b0;
    if (phase == 0 && cyc == 10) check("req_valid_low_when_full", {31'd0, imem_req_valid}, 32'd0);

    if (dec_busy) begin
      check("busy_no_pulse", {31'd0, RDY_BSY}, 32'd0);
      check("busy_insn_stable", instruction, cur.insn);
      check("busy_pc_stable", pc, cur.pc);
    end else if (RDY_BSY) begin
      pulse = 1'b1;
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pulse_unexpected: got pc %h, expected no pulse (cycle %0d)", pc, cyc);
      end else begin
        cur = exp_q.pop_front();
        check("pulse_pc", pc, cur.pc);
        check("pulse_insn", instruction, cur.insn);
`ifdef IFETCH_ILLEGAL_CHECK_EN
        check("pulse_illegal", {31'd0, illegal}, {31'd0, exp_illegal(cur.insn)});
`endif
      end
      if (pulse_chk) begin
        check("pc_after_redirect", pc, pulse_exp);
        pulse_chk = 1'b0;
      end
      if (n_pulses == 1) begin
        check("rsp_to_pulse_latency", 32'(cyc), 32'(first_rsp_cyc + 2));
        check("second_req_before_done", {31'd0, (n_acc >= 2)}, 32'd1);
      end
    end

    // Decoder: completion after a random stall; occasional stray strobes outside BUSY.
    dec_done = 1'b0;
    if (dec_busy) begin
      if (dec_cnt == 0) begin
        dec_done = 1'b1;
        dec_busy = 1'b0;
      end else begin
        dec_cnt--;
      end
    end else begin
      if (pulse) begin
        dec_busy = 1'b1;
        dec_cnt  = (n_pulses == 1) ? 10 : $urandom_range(dec_max, 0);
      end
      if ($urandom_range(99, 0) < spur_pct) dec_done = 1'b1;
    end

    // Memory: in-order responses, no backpressure.
    n_out = mq.size();
    imem_req_ready = ($urandom_range(99, 0) < ready_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    acc = imem_req_valid && imem_req_ready;

    redir = 1'b0;
    tgt   = $urandom();
    case (phase)
      1: begin
        if (!b1_done && n_out == 2) begin
          redir = 1'b1; tgt = 32'h0000_0103; b1_done = 1'b1; b1_cyc = cyc;
        end else if (b1_done && !b2_done && cyc > b1_cyc + 8 && imem_rsp_valid && acc) begin
          redir = 1'b1; tgt = 32'h0000_0203; b2_done = 1'b1;
        end
      end
      2: begin
        if (!c_done) begin
          redir = 1'b1; tgt = 32'hFFFF_FFF8; c_done = 1'b1;
        end
      end
      3: begin
        if ($urandom_range(99, 0) < redir_pct) begin
          redir = 1'b1;
          if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        end
      end
      default: ;
    endcase
    redirect_valid = redir;
    redirect_pc    = tgt;

    // Reference model: fetch stream advances by 4 per accepted request, restarts on redirect.
    if (acc) begin
      check("req_addr", imem_addr, exp_req_addr);
      if (acc_chk) begin
        check("req_addr_after_redirect", imem_addr, acc_exp);
        acc_chk = 1'b0;
      end
      if (wrap_chk) begin
        check("req_addr_wrap", imem_addr, 32'h0000_0000);
        wrap_chk = 1'b0;
      end
      if (exp_req_addr == 32'hFFFF_FFFC) wrap_chk = 1'b1;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = imem_addr;
      m.due  = due;
      mq.push_back(m);
      check("outstanding_cap", {31'd0, (mq.size() <= DEPTH)}, 32'd1);
      e.pc   = exp_req_addr;
      e.insn = mem_word(exp_req_addr);
      exp_q.push_back(e);
      exp_req_addr = exp_req_addr + 32'd4;
      n_acc++;
    end
    if (redir) begin
      exp_req_addr = {tgt[31:2], 2'b00};
      exp_q.delete();
      acc_chk   = 1'b1;
      acc_exp   = {tgt[31:2], 2'b00};
      pulse_chk = 1'b1;
      pulse_exp = {tgt[31:2], 2'b00};
      wrap_chk  = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_instruction", instruction, 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_rdy_bsy", {31'd0, RDY_BSY}, 32'd0);
`ifdef IFETCH_ILLEGAL_CHECK_EN
    check("rst_illegal", {31'd0, illegal}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_addr, RST_PC);

    phase = 0;
    repeat (40) cycle_step();

    phase = 1; lat_min = 2; lat_max = 3;
    repeat (60) cycle_step();

    phase = 2; lat_min = 1; lat_max = 2;
    repeat (40) cycle_step();

    phase = 3; ready_pct = 60; lat_min = 1; lat_max = 5; dec_max = 4; spur_pct = 10; redir_pct = 4;
    repeat (3000) cycle_step();

    phase = 4; ready_pct = 0; dec_max = 0; spur_pct = 0; redir_pct = 0;
    for (int i = 0; i < 300; i++) begin
      if (mq.size() == 0 && exp_q.size() == 0 && !dec_busy) break;
      cycle_step();
    end
    check("drain_all_presented", 32'(exp_q.size()), 32'd0);
    check("drain_mem_idle", 32'(mq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the decoder. It keeps the fetch PC and issues in-order word reads to instruction memory. Returned words are buffered in a small prefetch FIFO and presented one at a time to the decoder, using the decoder's `RDY_BSY` start pulse and a `dec_done` completion strobe. Supports a PC redirect that flushes buffered and in-flight fetches.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset.
- `FIFO_DEPTH`, 2, prefetch entries; power of two, ≥2; also the cap on outstanding requests.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  read data returned; in order, ≥1 cycle after acceptance, no backpressure.
- `imem_rsp_data`  in  32  returned instruction word.
- `redirect_valid`  in  1  one-cycle strobe: restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (forced 0).
- `instruction`  out  32  instruction presented to decoder; stable from pulse until `dec_done`.
- `pc`  out  32  address of `instruction`.
- `RDY_BSY`  out  1  one-cycle pulse: new `instruction` valid, decoder may start.
- `dec_done`  in  1  one-cycle strobe: decoder finished with `instruction`.
- `illegal`  out  1  only with `IFETCH_ILLEGAL_CHECK_EN`; see Configuration.

## Operation
- Request side: `imem_req_valid` = `outstanding + fifo_count < FIFO_DEPTH`. The request is accepted when `imem_req_valid && imem_req_ready`; on accept, `fetch_pc += 4` (wraps at 2^32) and `outstanding` increments.
- Response side: on `imem_rsp_valid`, decrement `outstanding`. If `discard_cnt > 0`, decrement it and drop the word. Otherwise push `{addr, data}` into the FIFO. Overflow is impossible by construction.
- Presentation FSM:
  - IDLE: if the FIFO is non-empty, load `instruction`/`pc` from the head and go to PULSE.
  - PULSE: `RDY_BSY`=1 for exactly this cycle, then go to BUSY.
  - BUSY: hold outputs. On `dec_done`, pop the head and go to IDLE.
- Back-to-back issue: the minimum gap between `RDY_BSY` pulses is `dec_done` + 2 cycles.
- Redirect:
  - `fetch_pc` ← `{redirect_pc[31:2],2'b00}`.
  - FIFO flushed, except the head entry when the FSM is in PULSE or BUSY; that instruction completes normally.
  - `discard_cnt` ← `outstanding` after this cycle's accept and response updates.
- Simultaneous events:
  - Redirect and request accept in the same cycle: the accepted request counts as stale. `imem_addr` that cycle is the old PC.
  - Redirect and response in the same cycle: the response is dropped.
  - Redirect and `dec_done` in the same cycle: the pop happens and the FIFO ends empty.
- `dec_done` outside BUSY is ignored.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_addr`=`RESET_PC`.
  - `instruction`=0, `pc`=`RESET_PC`, `RDY_BSY`=0, `illegal`=0.
  - FSM in IDLE, all counters 0.
- Reset mid-operation: asynchronous clear. Any in-flight memory responses arriving after reset release are accepted as valid. The environment must drain memory during reset.
- First cycle after `rst` deasserts: `imem_req_valid`=1, `imem_addr`=`RESET_PC`.
- Response-to-pulse latency: response in cycle N, FIFO write at edge N; IDLE→PULSE load at N+1; `RDY_BSY` high in cycle N+2 when the FSM was idle and the FIFO was empty.
- All outputs are registered except `imem_req_valid`, which is combinational from counters only.

## Configuration
- `IFETCH_ILLEGAL_CHECK_EN` defined:
  - `illegal` is registered alongside `instruction`. It is 1 when `instruction[6:0]` is neither 7'b0110011 (R-type) nor 7'b0010011 (I-type).
  - An illegal instruction still pulses `RDY_BSY`.
- Undefined: `illegal` port absent and no check logic.

## Structure
- Shared package `riscv_pkg`: `R_TYPE_OP`, `I_TYPE_OP` opcode constants, the default `RESET_PC`, and a fetch-entry struct `{pc[31:0], insn[31:0]}`.
- One sub-module, `ifetch_fifo`: synchronous FIFO with parameter `DEPTH`, push/pop/flush, keep-head-on-flush control, and count output.

## Test plan
- Reset release, memory with 1-cycle latency returning 0x00A00093 at 0x0: `RDY_BSY` pulses with `pc`=0x0 and `instruction`=0x00A00093. The second request, to 0x4, issues before `dec_done`.
- `dec_done` delayed 10 cycles: `instruction` stays stable. There are no further `RDY_BSY` pulses. `imem_req_valid` drops after 2 words are held.
- Redirect to 0x103 while 2 requests are outstanding: both responses are dropped. The next request address is 0x100, and the next `pc` presented is 0x100.
- Redirect in the same cycle as a response and a request accept: no stale word is ever presented, and the count of discarded responses equals 2.
- Fetch from 0xFFFFFFFC: the next `imem_addr` is 0x00000000.
- With `IFETCH_ILLEGAL_CHECK_EN`, word 0x00000073: `illegal`=1 with the `RDY_BSY` pulse. For 0x002081B3, `illegal`=0.
